// File: rtl/sigmoid_sym_pipe_pkg.sv
// Shared definitions for the symmetric sigmoid pipeline.
// Q4.16 constants, PWL breakpoints, offsets and shifts, and the sample type.
package sigmoid_pkg;

  localparam int unsigned SDW = 20;

  typedef logic [SDW-1:0] sample_t;

  // Q4.16 constants (1.0 = 65536)
  localparam sample_t ONE    = 20'd65536;
  localparam sample_t HALF   = 20'd32768;
  localparam sample_t BREAK0 = 20'd65536;
  localparam sample_t BREAK1 = 20'd155648;
  localparam sample_t SAT_X  = 20'd327680;

  // segment offsets
  localparam sample_t OFF0 = 20'd32768;
  localparam sample_t OFF1 = 20'd40960;
  localparam sample_t OFF2 = 20'd55296;

  // segment slopes as right shifts (1/4, 1/8, 1/32)
  localparam int unsigned SH0 = 2;
  localparam int unsigned SH1 = 3;
  localparam int unsigned SH2 = 5;

endpackage

// File: rtl/sigmoid_sym_pipe_if.sv
// Streaming bus for sigmoid_sym_pipe.
// Input stream: in_data/in_valid/in_ready. Output stream: out_data/out_valid/out_ready.
// Side band: sat_clr (clear) and sat_count (saturation-event counter).
// master = producer/consumer environment, slave = the pipeline.
interface sigmoid_sym_pipe_if #(
  parameter int DW = 20,
  parameter int CW = 16
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          sat_clr;
  logic [CW-1:0] sat_count;

  modport master (
    output in_data, in_valid, out_ready, sat_clr,
    input  in_ready, out_data, out_valid, sat_count
  );

  modport slave (
    input  in_data, in_valid, out_ready, sat_clr,
    output in_ready, out_data, out_valid, sat_count
  );
endinterface

// File: rtl/sigmoid_sym_pipe_pwl_seg.sv
// Combinational positive-half piecewise-linear sigmoid.
// Ports: m   - unsigned Q4.16 magnitude
//        z   - sigmoid(m), unsigned Q4.16, range 32768..65536
//        sat - magnitude at or beyond the saturation point
module sigmoid_pwl_seg
  import sigmoid_pkg::*;
(
  input  sample_t m,
  output sample_t z,
  output logic    sat
);

  always_comb begin
    z   = ONE;
    sat = 1'b0;
    if (m >= SAT_X) begin
      z   = ONE;
      sat = 1'b1;
    end else if (m >= BREAK1) begin
      z = (m >> SH2) + OFF2;
    end else if (m >= BREAK0) begin
      z = (m >> SH1) + OFF1;
    end else begin
      z = (m >> SH0) + OFF0;
    end
  end

endmodule

// File: rtl/sigmoid_sym_pipe.sv
// Three-stage streaming sigmoid: S1 fold to magnitude, S2 PWL, S3 symmetry.
// Ports: clk, rst (synchronous, active-high), bus (slave side of
// sigmoid_sym_pipe_if: in/out valid-ready streams, sat_clr, sat_count).
module sigmoid_sym_pipe
  import sigmoid_pkg::*;
#(
  parameter int DW = 20,
  parameter int CW = 16
) (
  input  logic               clk,
  input  logic               rst,
  sigmoid_sym_pipe_if.slave  bus
);

  logic          v1, v2, v3;
  logic          r1, r2, r3;
  sample_t       m1, z2, od3;
  logic          neg1, neg2;
  logic          sat2, sat3;
  sample_t       fold;
  sample_t       z_c;
  logic          sat_c;
  logic [CW-1:0] sat_cnt;

  // per-stage ready: a stage can load if empty or its content moves on
  assign r3 = !v3 || bus.out_ready;
  assign r2 = !v2 || r3;
  assign r1 = !v1 || r2;

  // two's-complement magnitude; -2^19 maps to 2^19, still representable unsigned
  always_comb begin
    fold = bus.in_data;
    if (bus.in_data[DW-1]) fold = ~bus.in_data + 20'd1;
  end

  sigmoid_pwl_seg u_pwl (
    .m   (m1),
    .z   (z_c),
    .sat (sat_c)
  );

  // data registers only load on a valid upstream beat so idle inputs never leak
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      od3     <= '0;
      sat_cnt <= '0;
    end else begin
      if (r1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          m1   <= fold;
          neg1 <= bus.in_data[DW-1];
        end
      end
      if (r2) begin
        v2 <= v1;
        if (v1) begin
          z2   <= z_c;
          neg2 <= neg1;
          sat2 <= sat_c;
        end
      end
      if (r3) begin
        v3 <= v2;
        if (v2) begin
          od3  <= neg2 ? (ONE - z2) : z2;
          sat3 <= sat2;
        end
      end
      if (bus.sat_clr) begin
        sat_cnt <= '0;
      end else if (v3 && bus.out_ready && sat3 && (sat_cnt != '1)) begin
        sat_cnt <= sat_cnt + CW'(1);
      end
    end
  end

  assign bus.in_ready  = r1;
  assign bus.out_valid = v3;
  assign bus.out_data  = od3;
  assign bus.sat_count = sat_cnt;

endmodule

// File: tb/tb_sigmoid_sym_pipe.sv
// Self-checking bench for sigmoid_sym_pipe: directed cases plus randomized
// stream checked against an arithmetic reference model and a scoreboard.
module tb_sigmoid_sym_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sigmoid_sym_pipe_if #(.DW(20), .CW(16)) bus ();

  sigmoid_sym_pipe #(.DW(20), .CW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int exp;
    bit sat;
    int acc;
  } item_t;

  item_t sb[$];
  item_t it_m;
  int    x_m;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  bit    armed = 0;
  bit    lat_on = 0;
  bit    rand_rdy = 0;
  int    sat_model = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // sigmoid from its definition: PWL on |x|, then sigma(-x) = 1 - sigma(x)
  function automatic int ref_sig(input int x);
    int m, z;
    m = (x < 0) ? -x : x;
    if (m >= 327680)      z = 65536;
    else if (m >= 155648) z = m / 32 + 55296;
    else if (m >= 65536)  z = m / 8 + 40960;
    else                  z = m / 4 + 32768;
    return (x < 0) ? 65536 - z : z;
  endfunction

  // monitor: sampled on the falling edge, transfers take effect at the next rise
  always @(negedge clk) begin
    if (armed) chk("sat_count", bus.sat_count, sat_model);
    if (rst) begin
      sb.delete();
      sat_model = 0;
      armed = 1;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", bus.out_data, -1);
        end else begin
          it_m = sb.pop_front();
          chk("out_data", bus.out_data, it_m.exp);
          if (lat_on) chk("latency", cyc - it_m.acc, 3);
          if (bus.sat_clr) sat_model = 0;
          else if (it_m.sat && sat_model < 65535) sat_model++;
        end
      end else if (bus.sat_clr) begin
        sat_model = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        x_m = $signed(bus.in_data);
        sb.push_back('{ref_sig(x_m), ((x_m < 0 ? -x_m : x_m) >= 327680), cyc});
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x);
    bit acc;
    bus.in_data  = x[19:0];
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      if (acc) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = 20'($urandom);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !bus.out_valid) return;
      tick();
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic wait_out_valid();
    for (int i = 0; i < 50; i++) begin
      if (bus.out_valid) return;
      tick();
    end
    chk("out_valid_timeout", 0, 1);
  endtask

  int  s[8];
  int  k;
  bit  acc;
  bit  have_prev;
  logic [19:0] prev;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    bus.sat_clr   = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready",  bus.in_ready, 1);
    chk("rst_out_data",  bus.out_data, 0);
    chk("rst_sat_count", bus.sat_count, 0);
    tick();

    // positive and negative segments, back to back, latency checked
    lat_on = 1;
    send(0); send(32768); send(65536); send(200000);
    send(-65536); send(-200000); send(-32768);
    drain();
    lat_on = 0;

    // saturation, extreme codes and counter
    send(327680); send(-524288); send(524287);
    drain();
    chk("sat_after3", bus.sat_count, 3);
    bus.out_ready = 1'b0;
    send(400000);
    idle();
    wait_out_valid();
    bus.sat_clr   = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    chk("sat_clr_prio", bus.sat_count, 0);
    drain();

    // stall: out_ready low for 6 cycles with input held valid
    for (int i = 0; i < 8; i++) s[i] = i * 70000 - 250000;
    bus.out_ready = 1'b0;
    k = 0;
    have_prev = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_data  = s[k][19:0];
      bus.in_valid = 1'b1;
      @(negedge clk);
      acc = bus.in_ready;
      if (bus.out_valid) begin
        if (have_prev) chk("stall_hold", bus.out_data, prev);
        prev = bus.out_data;
        have_prev = 1;
      end
      tick();
      if (acc) k++;
    end
    chk("stall_accepts", k, 3);
    chk("stall_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    while (k < 8) begin
      send(s[k]);
      k++;
    end
    drain();

    // random stream with random back-pressure
    rand_rdy = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        tick();
      end
      send($signed(20'($urandom)));
    end
    idle();
    rand_rdy = 0;
    tick();
    bus.out_ready = 1'b1;
    drain();

    // reset with 3 samples in flight
    bus.out_ready = 1'b0;
    send(327680); send(-400000); send(100000);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_sat_count", bus.sat_count, 0);
    chk("midrst_in_ready",  bus.in_ready, 1);
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    chk("midrst_no_emit", bus.out_valid, 0);
    lat_on = 1;
    send(100);
    idle();
    wait_out_valid();
    chk("post_rst_100", bus.out_data, 32793);
    drain();
    lat_on = 0;

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sigmoid_sym_pipe.md
Name: sigmoid_sym_pipe

Overview:
- Streaming, pipelined sigmoid evaluator for signed fixed-point activations.
- Takes a signed input, folds it to a magnitude, evaluates the positive-half piecewise-linear sigmoid, then applies the symmetry sigma(-x) = 1 - sigma(x).
- Sits between the accumulator/activation bus and downstream quantisation. Uses valid/ready handshakes on both sides, 3-stage pipeline, one sample per clock when unstalled.

Parameters:
- DW, 20, data width. Input is signed Q4.16, output is unsigned Q4.16 (1.0 = 65536). Only 20 is supported and verified.
- CW, 16, width of the saturation-event counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  DW  signed two's-complement Q4.16 sample
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept this cycle
- out_data  out  DW  unsigned Q4.16 sigmoid result, range 0..65536
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts this cycle
- sat_clr  in  1  synchronous clear of sat_count
- sat_count  out  CW  number of delivered samples with |x| >= 5.0; saturates at all-ones

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state changes on the rising edge of clk.
- Reset values: all stage valids = 0, out_valid = 0, out_data = 0, sat_count = 0. in_ready = 1 in the cycle after reset deasserts.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - out_data is held stable while out_valid && !out_ready.
- Stage S1, fold:
  - m = |in_data| as a DW-bit unsigned value. -524288 gives m = 524288, with no overflow.
  - Register m, neg = in_data[DW-1], and a valid bit.
- Stage S2, PWL on the magnitude (m treated as unsigned):
  - m >= 327680: z = 65536
  - 155648 <= m < 327680: z = (m>>5) + 55296
  - 65536 <= m < 155648: z = (m>>3) + 40960
  - m < 65536: z = (m>>2) + 32768
  - Register z, neg, sat = (m >= 327680), and a valid bit.
- Stage S3, symmetry:
  - out_data = neg ? 65536 - z : z. The subtraction is DW-bit with no underflow, since z >= 32768.
  - in_data = 0 gives 32768. neg is 0 in that case, so no special case is needed.
- Per-stage flow control:
  - ready_k = !valid_k || ready_(k+1), with ready_4 = out_ready and in_ready = ready_1.
  - A stage loads when ready_k is high. It clears valid_k when ready_k is high and there is no upstream valid.
  - No bubbles are inserted when the pipe runs. Full throughput is 1 sample per cycle.
  - in_ready may depend combinationally on out_ready. That path is accepted.
- Latency: a sample accepted at edge N is presented with out_valid at edge N+3 when unstalled.
- Ordering: strict FIFO, with no drop and no duplication under any out_ready pattern. Capacity is 3 samples in flight.
- sat_count:
  - Increments on each output transfer whose S3 sat flag is set.
  - Holds at 2^CW-1 once reached.
  - sat_clr has priority over the increment: when clear and increment coincide, the result is 0.
- Reset mid-operation: all in-flight samples are discarded and none are ever emitted. sat_count is cleared. The first post-reset accept behaves as from cold.
- Inputs in the X state while in_valid = 0 must not affect outputs.

Decomposition:
- Shared package sigmoid_pkg holds:
  - Q4.16 constants: ONE = 65536, HALF = 32768, BREAK0 = 65536, BREAK1 = 155648, SAT_X = 327680.
  - Offsets: OFF0 = 32768, OFF1 = 40960, OFF2 = 55296.
  - Shifts: 2, 3, 5.
  - A typedef for the DW-bit sample.
- Sub-module sigmoid_pwl_seg: purely combinational magnitude-to-z evaluator plus the sat flag, instantiated in S2.
- Pipeline registers, handshake, symmetry and counter live in the top module.

Test Plan:
- Send 0, 32768, 65536, 200000, one per cycle, with out_ready = 1 → outputs 32768, 40960, 49152, 61546 on consecutive cycles, first output 3 cycles after the first accept.
- Send -65536, -200000, -32768 → outputs 16384, 3990, 24576.
- Send 327680, -524288, 524287 → outputs 65536, 0, 65536, and sat_count reaches 3. Pulse sat_clr together with a saturating output transfer → sat_count = 0.
- Stream 8 samples with in_valid held high while out_ready = 0 for 6 cycles:
  - in_ready drops after exactly 3 accepts.
  - out_data stays stable while stalled.
  - After out_ready rises, all 8 results arrive in order with no loss or duplication.
- Random out_ready (50%) with 1000 random signed inputs, checked against a reference model → exact match, in order.
- Assert rst for 1 cycle while 3 samples are in flight → out_valid = 0 the next cycle, none of those samples are emitted, sat_count = 0, and a new input 100 yields 32793 after 3 cycles.
